nabp_image_writer: RTL and testbench
====================================

NABP_IMAGE_WRITER -- requirements
Module: nabp_image_writer

Interface
REQ-001 SHALL have parameter NO_OF_PE, default `kNoOfPartitions (4): number of processing elements drained.
REQ-002 SHALL have parameter PIXELS_PER_PE, default `kPixelsPerPartition (64): pixels each PE emits per frame.
REQ-003 SHALL have parameter IN_W, default `kFilteredDataLength (16): signed PE result width.
REQ-004 SHALL have parameter OUT_W, default `kImageDataLength (8): unsigned image pixel width.
REQ-005 SHALL have parameter ADDR_W, default `kImageAddressLength (8): image RAM address width, at least clog2(NO_OF_PE*PIXELS_PER_PE).
REQ-006 SHALL use one clock; reset is synchronous and active-high.
REQ-007 clk  in  1  sole clock, rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 hs_kick  in  1  host start pulse.
REQ-010 hs_done  out  1  one-cycle pulse when the frame is fully written.
REQ-011 pe_valid  in  NO_OF_PE  per-PE result available.
REQ-012 pe_val  in  NO_OF_PE*IN_W  PE results; PE i occupies bits [IN_W*(i+1)-1 : IN_W*i].
REQ-013 pe_ready  out  NO_OF_PE  one-hot or zero; the result of PE i is consumed on a cycle with pe_valid[i] and pe_ready[i] both high.
REQ-014 im_stall  in  1  image RAM cannot accept a write this cycle.
REQ-015 im_wr_en, im_addr, im_data  out  1, ADDR_W, OUT_W  registered image RAM write port.

Function
REQ-016 States SHALL be IDLE, DRAIN and DONE.
REQ-017 IDLE: hs_kick SHALL clear all per-PE counters and move to DRAIN next cycle.
REQ-018 DRAIN, im_stall low: a round-robin arbiter SHALL grant one PE with pe_valid high and counter < PIXELS_PER_PE.
- Search starts one above the last granted PE.
- After reset, search starts at PE 0.
REQ-019 A grant SHALL:
- raise pe_ready for that PE in the same cycle, combinationally;
- on the next edge, register im_wr_en=1, im_addr=sel*PIXELS_PER_PE+count[sel] and im_data=conv(pe_val[sel]);
- increment count[sel].
Write latency is 1 cycle.
REQ-020 When im_stall is high, pe_ready SHALL be all zero, im_wr_en SHALL be 0 next cycle, and the arbiter pointer and counters SHALL hold.
REQ-021 PEs whose counter equals PIXELS_PER_PE SHALL never be granted, even if pe_valid is high.
REQ-022 When every counter equals PIXELS_PER_PE and the final write is registered, the block SHALL enter DONE; DONE SHALL pulse hs_done for one cycle and return to IDLE.
REQ-023 hs_kick outside IDLE SHALL be ignored.
REQ-024 With no grant, im_wr_en SHALL be 0; im_addr and im_data SHALL hold their last values.
REQ-025 Sustained throughput SHALL be one pixel per cycle with no stall.

Reset
REQ-026 While reset is high (synchronous), the block SHALL:
- enter IDLE;
- set all counters to 0 and the arbiter pointer to PE 0;
- drive hs_done=0, im_wr_en=0, im_addr=0, im_data=0 and pe_ready=0.
REQ-027 Reset mid-DRAIN SHALL abandon the frame with no further writes; a new hs_kick is required.

Configuration
REQ-028 Macro NABP_IMAGE_WRITER_CLAMP_EN:
- Defined: conv SHALL clamp negative inputs to 0, saturate values above 2^OUT_W-1 to 2^OUT_W-1, and otherwise pass the low OUT_W bits.
- Undefined: conv SHALL be pure truncation to the low OUT_W bits.

Structure
REQ-029 The shared defines package SHALL hold `kNoOfPartitions, `kPixelsPerPartition, `kImageDataLength, `kImageAddressLength and the writer state encoding.
REQ-030 Round-robin arbitration SHALL be a sub-module nabp_rr_arbiter (request vector, enable, one-hot grant, registered pointer).

Verification
REQ-031 Reset, then NO_OF_PE=4, PIXELS_PER_PE=4, all pe_valid high, hs_kick -> 16 writes on consecutive cycles; grant order 0,1,2,3 repeating; addresses 0,4,8,12,1,5,...; hs_done 1 cycle after write 16.
REQ-032 Only pe_valid[2] high -> PE 2 writes addresses 8..11 back-to-back; then no further grants and hs_done stays 0 until the other PEs finish.
REQ-033 im_stall high for 3 cycles mid-frame -> pe_ready all zero and im_wr_en 0 during those cycles; no pixel lost or duplicated; all 16 addresses written exactly once.
REQ-034 CLAMP_EN defined, pe_val inputs -5, 300, 0x007F -> im_data 0, 255, 127; undefined -> 0xFB, 0x2C, 0x7F.
REQ-035 Reset asserted after 6 writes -> im_wr_en 0 thereafter, no hs_done; a second hs_kick restarts from address 0 with pointer at PE 0.

Source files
------------

// File: rtl/nabp_image_writer_pkg.sv
// -----------------------------------------------------------------------------
// nabp_image_writer_pkg
// Shared definitions for the NABP image writer: default geometry of the
// partitioned back-projector, the writer state encoding and a small width
// helper used by the writer and its round-robin arbiter.
// -----------------------------------------------------------------------------
package nabp_image_writer_pkg;

    localparam int kNoOfPartitions     = 4;   // processing elements drained per frame
    localparam int kPixelsPerPartition = 64;  // pixels each PE emits per frame
    localparam int kFilteredDataLength = 16;  // signed PE result width
    localparam int kImageDataLength    = 8;   // unsigned image pixel width
    localparam int kImageAddressLength = 8;   // image RAM address width

    typedef enum logic [1:0] {
        WR_IDLE  = 2'd0,
        WR_DRAIN = 2'd1,
        WR_DONE  = 2'd2
    } writer_state_e;

    // Width of an index into n items; never below one bit so that a
    // single-entry configuration still has a legal vector.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nabp_rr_arbiter.sv
// -----------------------------------------------------------------------------
// nabp_rr_arbiter
// Round-robin arbiter. The search for a requester starts one above the last
// granted index (index 0 after reset) and wraps. The pointer only advances
// when a grant is actually issued, so a disabled cycle leaves it unchanged.
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high reset (pointer -> 0)
//   req        in   N request lines
//   en         in   arbitration enable; no grant while low
//   grant      out  one-hot grant (zero when nothing granted)
//   grant_idx  out  binary index of the granted requester
//   grant_vld  out  a grant is issued this cycle
// -----------------------------------------------------------------------------
module nabp_rr_arbiter
    import nabp_image_writer_pkg::*;
#(
    parameter  int N     = 4,
    localparam int IDX_W = idx_width(N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic             en,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_vld
);

    logic [IDX_W-1:0] ptr_q, ptr_d;

    // NOTE: every variable assigned in an always_comb gets a default first so
    // that no path leaves it unassigned and no latch is inferred.
    always_comb begin
        int idx;
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        idx       = 0;
        if (en) begin
            for (int i = 0; i < N; i++) begin
                idx = int'(ptr_q) + i;
                if (idx >= N) idx = idx - N;
                if (!grant_vld && req[idx]) begin
                    grant_vld  = 1'b1;
                    grant[idx] = 1'b1;
                    grant_idx  = IDX_W'(idx);
                end
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_vld) begin
            ptr_d = (int'(grant_idx) == N - 1) ? '0 : grant_idx + IDX_W'(1);
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so all
    // flops sample their inputs from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

endmodule

// File: rtl/nabp_image_writer.sv
// -----------------------------------------------------------------------------
// nabp_image_writer
// Drains PIXELS_PER_PE results from each of NO_OF_PE processing elements into
// an image RAM. A round-robin arbiter picks one PE per cycle among those with
// a valid result and pixels still owed; the pixel is converted to image width
// and written one cycle later at sel*PIXELS_PER_PE + count[sel]. When every
// PE has delivered its full share a one-cycle hs_done pulse is issued.
//
// Build option
//   NABP_IMAGE_WRITER_CLAMP_EN  defined: negative results clamp to 0, results
//                               above the pixel range saturate to all ones.
//                               undefined: results are truncated to OUT_W bits.
//
// Ports
//   clk       in   clock, rising edge
//   reset     in   synchronous active-high reset
//   hs_kick   in   host start pulse (honoured only in IDLE)
//   hs_done   out  one-cycle pulse once the frame is fully written
//   pe_valid  in   per-PE result available
//   pe_val    in   PE results, PE i at [IN_W*(i+1)-1 : IN_W*i]
//   pe_ready  out  one-hot or zero; result consumed when valid & ready
//   im_stall  in   image RAM cannot accept a write this cycle
//   im_wr_en  out  registered image RAM write enable
//   im_addr   out  registered image RAM address (held when idle)
//   im_data   out  registered image RAM data (held when idle)
// -----------------------------------------------------------------------------
module nabp_image_writer
    import nabp_image_writer_pkg::*;
#(
    parameter int NO_OF_PE      = kNoOfPartitions,
    parameter int PIXELS_PER_PE = kPixelsPerPartition,
    parameter int IN_W          = kFilteredDataLength,
    parameter int OUT_W         = kImageDataLength,
    parameter int ADDR_W        = kImageAddressLength
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     hs_kick,
    output logic                     hs_done,
    input  logic [NO_OF_PE-1:0]      pe_valid,
    input  logic [NO_OF_PE*IN_W-1:0] pe_val,
    output logic [NO_OF_PE-1:0]      pe_ready,
    input  logic                     im_stall,
    output logic                     im_wr_en,
    output logic [ADDR_W-1:0]        im_addr,
    output logic [OUT_W-1:0]         im_data
);

    localparam int IDX_W = idx_width(NO_OF_PE);
    localparam int CNT_W = $clog2(PIXELS_PER_PE + 1);

    writer_state_e    state_q, state_d;
    logic [CNT_W-1:0] count_q [NO_OF_PE];
    logic [CNT_W-1:0] count_d [NO_OF_PE];
    logic             wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [OUT_W-1:0] data_q, data_d;

    logic [NO_OF_PE-1:0] req;
    logic [NO_OF_PE-1:0] grant;
    logic [IDX_W-1:0]    grant_idx;
    logic                grant_vld;
    logic                arb_en;
    logic                all_full;

    function automatic logic [OUT_W-1:0] conv(input logic [IN_W-1:0] v);
`ifdef NABP_IMAGE_WRITER_CLAMP_EN
        if (v[IN_W-1])               return '0;  // negative
        else if ((v >> OUT_W) != '0) return '1;  // above pixel range
        else                         return v[OUT_W-1:0];
`else
        return v[OUT_W-1:0];
`endif
    endfunction

    // A PE may only compete while it still owes pixels for this frame.
    always_comb begin
        all_full = 1'b1;
        for (int i = 0; i < NO_OF_PE; i++) begin
            req[i] = pe_valid[i] && (int'(count_q[i]) != PIXELS_PER_PE);
            if (int'(count_q[i]) != PIXELS_PER_PE) all_full = 1'b0;
        end
    end

    nabp_rr_arbiter #(
        .N(NO_OF_PE)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .en        (arb_en),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) state_q <= WR_IDLE;
        else       state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    // DRAIN sees all counters full in the cycle the last write is on the
    // port, so DONE (and hs_done) follows the final write by one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            WR_IDLE:  if (hs_kick)  state_d = WR_DRAIN;
            WR_DRAIN: if (all_full) state_d = WR_DONE;
            WR_DONE:                state_d = WR_IDLE;
            default:                state_d = WR_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Reset is folded into the enable so pe_ready is already low during the
    // reset cycle, before the state register has returned to IDLE.
    always_comb begin
        hs_done = (state_q == WR_DONE);
        arb_en  = (state_q == WR_DRAIN) && !im_stall && !reset;
    end

    assign pe_ready = grant;

    // ---------------- datapath ----------------
    always_comb begin
        for (int i = 0; i < NO_OF_PE; i++) count_d[i] = count_q[i];
        wr_en_d = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;

        if (state_q == WR_IDLE && hs_kick) begin
            for (int i = 0; i < NO_OF_PE; i++) count_d[i] = '0;
        end

        if (grant_vld) begin
            wr_en_d            = 1'b1;
            addr_d             = ADDR_W'(grant_idx) * ADDR_W'(PIXELS_PER_PE)
                               + ADDR_W'(count_q[grant_idx]);
            data_d             = conv(pe_val[int'(grant_idx)*IN_W +: IN_W]);
            count_d[grant_idx] = count_q[grant_idx] + CNT_W'(1);
        end
    end

    // NOTE: the per-PE counter array is small flop storage, not a RAM, and is
    // reset explicitly so a frame abandoned by reset leaves no stale counts.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NO_OF_PE; i++) count_q[i] <= '0;
            wr_en_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            for (int i = 0; i < NO_OF_PE; i++) count_q[i] <= count_d[i];
            wr_en_q <= wr_en_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign im_wr_en = wr_en_q;
    assign im_addr  = addr_q;
    assign im_data  = data_q;

endmodule

// File: tb/tb_nabp_image_writer.sv
// -----------------------------------------------------------------------------
// tb_nabp_image_writer
// Directed bench for nabp_image_writer with NO_OF_PE=4, PIXELS_PER_PE=4.
// PE i presents value i*16 + n + 1 for its n-th pixel, so each write carries
// a recognisable address/data pair.
// -----------------------------------------------------------------------------
module tb_nabp_image_writer;

    localparam int NPE = 4;
    localparam int PPE = 4;
    localparam int IW  = 16;
    localparam int OW  = 8;
    localparam int AW  = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              hs_kick;
    logic              hs_done;
    logic [NPE-1:0]    pe_valid;
    logic [NPE*IW-1:0] pe_val;
    logic [NPE-1:0]    pe_ready;
    logic              im_stall;
    logic              im_wr_en;
    logic [AW-1:0]     im_addr;
    logic [OW-1:0]     im_data;

    int n_vec  = 0;
    int n_miss = 0;
    int cnt [NPE];
    logic [15:0] seen;
    int dups;

    always #5 clk = ~clk;

    nabp_image_writer #(
        .NO_OF_PE      (NPE),
        .PIXELS_PER_PE (PPE),
        .IN_W          (IW),
        .OUT_W         (OW),
        .ADDR_W        (AW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .hs_kick  (hs_kick),
        .hs_done  (hs_done),
        .pe_valid (pe_valid),
        .pe_val   (pe_val),
        .pe_ready (pe_ready),
        .im_stall (im_stall),
        .im_wr_en (im_wr_en),
        .im_addr  (im_addr),
        .im_data  (im_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_vals();
        for (int i = 0; i < NPE; i++) pe_val[i*IW +: IW] = IW'(i*16 + cnt[i] + 1);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        hs_kick  = 1'b0;
        pe_valid = '0;
        im_stall = 1'b0;
        pe_val   = '0;
        tick();
        tick();
        check("rst_hs_done",  hs_done,  0);
        check("rst_wr_en",    im_wr_en, 0);
        check("rst_addr",     im_addr,  0);
        check("rst_data",     im_data,  0);
        check("rst_pe_ready", pe_ready, 0);
        reset = 1'b0;
        for (int i = 0; i < NPE; i++) cnt[i] = 0;
        seen = '0;
        dups = 0;
    endtask

    task automatic kick();
        hs_kick = 1'b1;
        tick();
        hs_kick = 1'b0;
    endtask

    // One granted cycle: PE pe must be ready now, its write appears next cycle.
    task automatic grant_write(input int pe, input string tag);
        load_vals();
        #1;
        check({tag, "_ready"}, pe_ready, 32'(1 << pe));
        tick();
        check({tag, "_wr_en"}, im_wr_en, 1);
        check({tag, "_addr"},  im_addr,  32'(pe*PPE + cnt[pe]));
        check({tag, "_data"},  im_data,  32'(pe*16 + cnt[pe] + 1));
        if (seen[im_addr[3:0]]) dups++;
        seen[im_addr[3:0]] = 1'b1;
        cnt[pe]++;
    endtask

    // Called in the cycle the last write is on the port.
    task automatic expect_done(input string tag, input int last_addr);
        #1;
        check({tag, "_ready_full"}, pe_ready, 0);
        check({tag, "_done_early"}, hs_done,  0);
        tick();
        check({tag, "_done"},       hs_done,  1);
        check({tag, "_wr_after"},   im_wr_en, 0);
        check({tag, "_addr_hold"},  im_addr,  32'(last_addr));
        tick();
        check({tag, "_done_pulse"}, hs_done,  0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int seq3 [3];
        logic [IW-1:0] cv_in  [3];
        logic [OW-1:0] cv_exp [3];
        int bad;

        // ---- full frame, all PEs valid: strict round robin ----
        do_reset();
        pe_valid = '1;
        kick();
        for (int k = 0; k < 16; k++) grant_write(k % 4, "t1");
        expect_done("t1", 15);

        // ---- only PE 2 valid, then the others finish ----
        do_reset();
        pe_valid = 4'b0100;
        kick();
        for (int k = 0; k < 4; k++) grant_write(2, "t2_pe2");
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            load_vals();
            #1;
            if (pe_ready != 0) bad++;
            tick();
            if (im_wr_en || hs_done) bad++;
        end
        check("t2_pe2_exhausted_quiet", bad, 0);
        pe_valid = '1;                 // PE 2 full: must be skipped
        seq3[0] = 3; seq3[1] = 0; seq3[2] = 1;
        for (int j = 0; j < 12; j++) grant_write(seq3[j % 3], "t2_rest");
        expect_done("t2", 7);

        // ---- three stall cycles mid-frame ----
        do_reset();
        pe_valid = '1;
        kick();
        for (int k = 0; k < 6; k++) grant_write(k % 4, "t3_pre");
        im_stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            load_vals();
            #1;
            check("t3_stall_ready", pe_ready, 0);
            tick();
            check("t3_stall_wr_en", im_wr_en, 0);
        end
        im_stall = 1'b0;
        for (int k = 6; k < 16; k++) grant_write(k % 4, "t3_post");
        check("t3_no_dups",  dups, 0);
        check("t3_coverage", seen, 16'hFFFF);
        expect_done("t3", 15);

        // ---- pixel conversion ----
        do_reset();
        pe_valid = 4'b0001;
        cv_in[0] = 16'hFFFB; cv_in[1] = 16'd300; cv_in[2] = 16'h007F;
`ifdef NABP_IMAGE_WRITER_CLAMP_EN
        cv_exp[0] = 8'h00; cv_exp[1] = 8'hFF; cv_exp[2] = 8'h7F;
`else
        cv_exp[0] = 8'hFB; cv_exp[1] = 8'h2C; cv_exp[2] = 8'h7F;
`endif
        kick();
        for (int j = 0; j < 3; j++) begin
            pe_val = '0;
            pe_val[IW-1:0] = cv_in[j];
            #1;
            check("t4_ready", pe_ready, 1);
            tick();
            check("t4_addr", im_addr, 32'(j));
            check("t4_data", im_data, 32'(cv_exp[j]));
        end

        // ---- reset mid-frame abandons it; new kick restarts at 0 ----
        do_reset();
        pe_valid = '1;
        kick();
        for (int k = 0; k < 6; k++) grant_write(k % 4, "t5_pre");
        reset = 1'b1;
        #1;
        check("t5_rst_ready", pe_ready, 0);
        tick();
        check("t5_rst_wr_en", im_wr_en, 0);
        reset = 1'b0;
        for (int i = 0; i < NPE; i++) cnt[i] = 0;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            load_vals();
            #1;
            if (pe_ready != 0) bad++;
            tick();
            if (im_wr_en || hs_done) bad++;
        end
        check("t5_quiet_after_reset", bad, 0);
        seen = '0;
        dups = 0;
        kick();
        for (int k = 0; k < 16; k++) grant_write(k % 4, "t5_restart");
        check("t5_coverage", seen, 16'hFFFF);
        expect_done("t5", 15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
